// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one 1-cycle-latency single-port SRAM between inst and data requesters.
// Data has priority with an inst starvation guard; define SRAM_ARB_PERF_EN to add perf counters.
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [DATA_W/8-1:0] inst_we,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_gnt,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
`ifdef SRAM_ARB_PERF_EN
  input  logic                perf_clr,
  output logic [31:0]         perf_inst_stall,
  output logic [31:0]         perf_data_acc,
`endif
  input  logic [DATA_W-1:0]   sram_rdata
);
  logic [3:0] starve_cnt;
  logic       resp_pend;
  logic       resp_owner;
  logic       inst_pri;
  always_comb begin
    inst_pri   = starve_cnt == 4'(STARVE_LIMIT);
    inst_gnt   = ~rst & inst_req & (~data_req | inst_pri);
    data_gnt   = ~rst & data_req & ~inst_gnt;
    sram_en    = inst_gnt | data_gnt;
    sram_we    = inst_gnt ? inst_we    : data_gnt ? data_we    : '0;
    sram_addr  = inst_gnt ? inst_addr  : data_gnt ? data_addr  : '0;
    sram_wdata = inst_gnt ? inst_wdata : data_gnt ? data_wdata : '0;
  end
  assign inst_rvalid = resp_pend & ~resp_owner;
  assign data_rvalid = resp_pend & resp_owner;
  assign inst_rdata  = sram_rdata;
  assign data_rdata  = sram_rdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      resp_pend  <= 1'b0;
      resp_owner <= 1'b0;
    end else begin
      starve_cnt <= (inst_req & ~inst_gnt) ? (inst_pri ? starve_cnt : starve_cnt + 4'd1) : 4'd0;
      resp_pend  <= sram_en & ~|sram_we;
      if (sram_en & ~|sram_we) resp_owner <= data_gnt;
    end
  end
`ifdef SRAM_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_inst_stall <= '0;
      perf_data_acc   <= '0;
    end else if (perf_clr) begin
      perf_inst_stall <= '0;
      perf_data_acc   <= '0;
    end else begin
      perf_inst_stall <= perf_inst_stall + 32'(inst_req & ~inst_gnt);
      perf_data_acc   <= perf_data_acc + 32'(data_gnt);
    end
  end
`endif
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed + random stimulus against a behavioural arbiter/SRAM reference model.
module tb_sram_port_arbiter;
  localparam int LIMIT = 4;
  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req, inst_gnt, data_gnt, inst_rvalid, data_rvalid, sram_en, perf_clr;
  logic [3:0]  inst_we, data_we, sram_we;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata, inst_rdata, data_rdata;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
`ifdef SRAM_ARB_PERF_EN
  logic [31:0] perf_inst_stall, perf_data_acc;
`endif
  int checks = 0, errors = 0;
  int wait_n = 0;
  bit pend = 0, owner = 0, gi = 0, gd = 0;
  logic [31:0] exp_rdata = '0;
  int unsigned pstall = 0, pacc = 0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] sram_mem [logic [31:0]];

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_we(inst_we), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
`ifdef SRAM_ARB_PERF_EN
    .perf_clr(perf_clr), .perf_inst_stall(perf_inst_stall), .perf_data_acc(perf_data_acc),
`endif
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Unwritten words hold an address-dependent pattern so misrouted reads are visible.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) o[8*i+:8] = n[8*i+:8];
    return o;
  endfunction

  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we == 4'd0)
        sram_rdata <= sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : init_word(sram_addr);
      else
        sram_mem[sram_addr] = merge(sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : init_word(sram_addr),
                                    sram_wdata, sram_we);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_i(input logic r, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    inst_req = r; inst_we = we; inst_addr = a; inst_wdata = d;
  endtask

  task automatic set_d(input logic r, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    data_req = r; data_we = we; data_addr = a; data_wdata = d;
  endtask

  // Checks the current cycle against the model, then advances the model across the next edge.
  task automatic step();
    logic [3:0]  ewe;
    logic [31:0] ea, ed, cur;
    #1;
    if (rst) begin wait_n = 0; pend = 0; pstall = 0; pacc = 0; end
    gi  = !rst && inst_req && (!data_req || wait_n >= LIMIT);
    gd  = !rst && data_req && !gi;
    ewe = gi ? inst_we : gd ? data_we : 4'd0;
    ea  = gi ? inst_addr : gd ? data_addr : 32'd0;
    ed  = gi ? inst_wdata : gd ? data_wdata : 32'd0;
    chk("inst_gnt", 64'(inst_gnt), 64'(gi));
    chk("data_gnt", 64'(data_gnt), 64'(gd));
    chk("sram_en", 64'(sram_en), 64'(gi | gd));
    chk("sram_we", 64'(sram_we), 64'(ewe));
    chk("sram_addr", 64'(sram_addr), 64'(ea));
    chk("sram_wdata", 64'(sram_wdata), 64'(ed));
    chk("inst_rvalid", 64'(inst_rvalid), 64'(pend && !owner));
    chk("data_rvalid", 64'(data_rvalid), 64'(pend && owner));
    if (pend && !owner) chk("inst_rdata", 64'(inst_rdata), 64'(exp_rdata));
    if (pend && owner) chk("data_rdata", 64'(data_rdata), 64'(exp_rdata));
`ifdef SRAM_ARB_PERF_EN
    chk("perf_inst_stall", 64'(perf_inst_stall), 64'(pstall));
    chk("perf_data_acc", 64'(perf_data_acc), 64'(pacc));
`endif
    if (!rst) begin
      pend  = (gi || gd) && ewe == 4'd0;
      owner = gd;
      if (gi || gd) begin
        cur = ref_mem.exists(ea) ? ref_mem[ea] : init_word(ea);
        if (ewe == 4'd0) exp_rdata = cur;
        else ref_mem[ea] = merge(cur, ed, ewe);
      end
      wait_n = (inst_req && !gi) ? wait_n + 1 : 0;
      pstall += (inst_req && !gi) ? 1 : 0;
      pacc   += gd ? 1 : 0;
      if (perf_clr) begin pstall = 0; pacc = 0; end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; perf_clr = 1'b0; sram_rdata = '0;
    set_i(1, 0, 32'h0, 0); set_d(1, 0, 32'h4, 0);
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    set_i(1, 0, 32'h1C00_0000, 0); set_d(0, 0, 0, 0);
    step();
    set_i(0, 0, 0, 0);
    step();
    perf_clr = 1'b1; step(); perf_clr = 1'b0;
    set_i(1, 0, 32'h40, 0); set_d(1, 0, 32'h80, 0);
    repeat (10) step();
`ifdef SRAM_ARB_PERF_EN
    chk("perf_stall_after_contention", 64'(perf_inst_stall), 64'd8);
    chk("perf_acc_after_contention", 64'(perf_data_acc), 64'd8);
    perf_clr = 1'b1; set_i(0, 0, 0, 0); set_d(0, 0, 0, 0); step(); perf_clr = 1'b0;
    chk("perf_stall_cleared", 64'(perf_inst_stall), 64'd0);
    chk("perf_acc_cleared", 64'(perf_data_acc), 64'd0);
`endif
    set_i(0, 0, 0, 0);
    set_d(1, 4'hF, 32'h100, 32'hDEAD_BEEF); step();
    set_d(1, 4'h0, 32'h100, 0); step();
    set_d(0, 0, 0, 0); step();
    set_d(1, 4'b0101, 32'h100, 32'h1122_3344); step();
    set_d(1, 4'h0, 32'h100, 0); step();
    set_d(0, 0, 0, 0); step();
    for (int k = 0; k < 4; k++) begin
      set_i(1, 0, 32'h200 + 32'(4 * k), 0); set_d(0, 0, 0, 0); step();
      set_i(0, 0, 0, 0); set_d(1, 0, 32'h300 + 32'(4 * k), 0); step();
    end
    set_d(0, 0, 0, 0); step();
    set_i(1, 0, 32'h44, 0); set_d(1, 0, 32'h84, 0);
    step(); step();
    rst = 1'b1; step();
    rst = 1'b0;
    repeat (7) step();
    for (int n = 0; n < 500; n++) begin
      if (!inst_req || gi)
        set_i($urandom_range(0, 3) != 0, $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15)),
              32'($urandom_range(0, 15)) << 2, $urandom);
      if (!data_req || gd)
        set_d($urandom_range(0, 3) != 0, $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15)),
              32'($urandom_range(0, 15)) << 2, $urandom);
      rst = $urandom_range(0, 99) == 0;
      perf_clr = $urandom_range(0, 29) == 0;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Shares one synchronous single-port SRAM between the instruction-fetch requester and the data-access requester. It uses a fixed one-cycle read latency. Accesses are pipelined, so one new access can be issued every cycle. Read data is routed back to the requester that issued the read. Data side has priority by default; a starvation guard forces an instruction grant after a bounded wait.

Parameters:
ADDR_W, 32, address width of both requesters and the SRAM
DATA_W, 32, data width; byte-enable width is DATA_W/8
STARVE_LIMIT, 4, consecutive denied inst-request cycles before inst gets priority (must be 1..15)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
inst_req  input  1  inst requester wants an access this cycle
inst_we  input  DATA_W/8  inst byte write enables; 0 = read
inst_addr  input  ADDR_W  inst access address
inst_wdata  input  DATA_W  inst write data
inst_gnt  output  1  inst access issued to the SRAM this cycle
inst_rvalid  output  1  inst read data valid this cycle
inst_rdata  output  DATA_W  inst read data
data_req / data_we / data_addr / data_wdata  input  1 / DATA_W/8 / ADDR_W / DATA_W  data requester, same meaning as the inst fields
data_gnt / data_rvalid / data_rdata  output  1 / 1 / DATA_W  data requester, same meaning as the inst fields
sram_en  output  1  SRAM access enable
sram_we  output  DATA_W/8  SRAM byte write enables
sram_addr  output  ADDR_W  SRAM address
sram_wdata  output  DATA_W  SRAM write data
sram_rdata  input  DATA_W  SRAM read data, valid one cycle after a read with sram_en=1

Behaviour:
- Grant and SRAM drive:
  - Grant logic is combinational.
  - At most one of inst_gnt/data_gnt is high in a cycle.
  - sram_en = inst_gnt | data_gnt.
  - sram_we/addr/wdata are muxed from the granted requester. With no grant they are driven to 0.
- Arbitration each cycle:
  - Only one requester asserting req: it is granted.
  - Both asserting req: data wins unless starve_cnt == STARVE_LIMIT, in which case inst wins.
- starve_cnt (4-bit register):
  - Reset value 0.
  - Increments when inst_req & ~inst_gnt, saturating at STARVE_LIMIT.
  - Clears to 0 on inst_gnt, or when inst_req is low.
- Response tracking:
  - Registers resp_pend and resp_owner (0 = inst, 1 = data).
  - On a cycle with a grant and sram_we == 0: resp_pend <= 1, resp_owner <= granted side.
  - Otherwise resp_pend <= 0.
- Response outputs:
  - inst_rvalid = resp_pend & ~resp_owner.
  - data_rvalid = resp_pend & resp_owner.
  - inst_rdata and data_rdata both equal sram_rdata. Consumers qualify with rvalid.
- Latency:
  - Grant in cycle N gives rvalid in cycle N+1. There is no response backpressure; the requester must accept the data.
  - Writes complete at grant and produce no rvalid.
- Back-to-back operation: a grant in cycle N+1 can coexist with the rvalid for cycle N. The two are fully independent.
- Requester contract: a requester must hold req/we/addr/wdata stable until it sees gnt. The arbiter does not latch requests.
- Reset:
  - rst asserted at any time immediately clears starve_cnt, resp_pend and resp_owner. Any pending response is discarded, with no rvalid after reset.
  - While rst = 1: inst_gnt = data_gnt = 0 and sram_en = 0, regardless of req.
- Outputs at reset: all gnt, rvalid and sram_* outputs are 0. rdata follows sram_rdata.

Optional Feature:
SRAM_ARB_PERF_EN
- When defined, adds:
  - input perf_clr (1 bit, synchronous clear).
  - output perf_inst_stall (32 bits): counts cycles with inst_req & ~inst_gnt.
  - output perf_data_acc (32 bits): counts data_gnt cycles.
- Both counters reset to 0 on rst or perf_clr and wrap at 2^32.
- When not defined, these ports and registers do not exist. Arbitration behaviour is identical either way.

Test Plan:
- Reset behaviour: rst=1 with both req=1 -> gnt=0, sram_en=0, rvalid=0. Release rst, only inst_req=1, addr 0x1C000000 -> inst_gnt=1 same cycle; inst_rvalid=1 next cycle with inst_rdata = sram_rdata.
- Data priority: both req held, STARVE_LIMIT=4 -> data_gnt cycles 0-3, inst_gnt cycle 4, starve_cnt returns to 0, data_gnt cycles 5-8, inst_gnt cycle 9.
- Mixed write/read: data write we=4'b1111, addr 0x100, wdata 0xDEADBEEF, then data read of 0x100 the next cycle -> no rvalid after the write; data_rvalid with 0xDEADBEEF one cycle after the read grant.
- Alternating reads: inst read and data read granted in consecutive cycles -> rvalid alternates inst/data; each rdata matches its own address; never both rvalid in the same cycle.
- Reset mid-operation: rst pulsed in the cycle after a read grant -> no rvalid appears and starve_cnt reads 0 afterwards.
- SRAM_ARB_PERF_EN defined: 10 cycles of contention -> perf_inst_stall=8, perf_data_acc=8. Then perf_clr -> both 0 next cycle.
